// File: rtl/edid_i2c_reader_if.sv
`default_nettype none
// =====================================================================
// Module   : edid_i2c_reader_if
// Brief    : Read-request handshake and I2C pin bundle for edid_i2c_reader
// Revision : 1.0
// =====================================================================
interface edid_i2c_reader_if;
    logic       start;
    logic [7:0] start_addr;
    logic [8:0] byte_count;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_i;

    modport slave (
        input  start, start_addr, byte_count, sda_i,
        output busy, done, error, rd_data, rd_valid, scl_oe, sda_oe
    );

    modport master (
        output start, start_addr, byte_count, sda_i,
        input  busy, done, error, rd_data, rd_valid, scl_oe, sda_oe
    );
endinterface
`default_nettype wire

// File: rtl/edid_i2c_reader.sv
`default_nettype none
// =====================================================================
// Module   : edid_i2c_reader
// Brief    : I2C master that reads byte_count EDID bytes from start_addr
// Revision : 1.0
// =====================================================================
module edid_i2c_reader #(
    parameter int       CLK_DIV  = 625,
    parameter bit [6:0] DEV_ADDR = 7'h50
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    edid_i2c_reader_if.slave bus
);
    localparam int            QW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_CTRL_W, ST_ACK_W, ST_ADDR, ST_ACK_A, ST_RSTART,
        ST_CTRL_R, ST_ACK_R, ST_READ, ST_MACK, ST_STOP, ST_FIN
    } state_t;

    state_t        state, state_nx;
    logic [QW-1:0] qcnt;
    logic [1:0]    quarter;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sh, rx_sh, addr_q;
    logic [8:0]    remain;
    logic          err_flag, ack_bit;
    logic [1:0]    sda_sync;
    logic          active, q_end, bit_end, byte_end, sample_pt, accept;
    logic          scl_d, sda_d;

    assign active    = (state != ST_IDLE) && (state != ST_FIN);
    assign q_end     = active && (qcnt == Q_LAST);
    assign bit_end   = q_end && (quarter == 2'd3);
    assign byte_end  = bit_end && (bit_cnt == 3'd7);
    assign sample_pt = q_end && (quarter == 2'd2);
    assign accept    = !active && bus.start;

    assign bus.busy  = active;
    assign bus.done  = (state == ST_FIN) && !err_flag;
    assign bus.error = (state == ST_FIN) && err_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Line levels are decoded per quarter here and registered below so the pins never glitch.
    always_comb begin
        state_nx = state;
        scl_d    = 1'b0;
        sda_d    = 1'b0;
        case (state)
            ST_IDLE, ST_FIN: begin
                state_nx = ST_IDLE;
                if (bus.start) begin
                    if (bus.byte_count == 9'd0) state_nx = ST_FIN;
                    else                        state_nx = ST_START;
                end
            end
            ST_START: begin
                scl_d = (quarter == 2'd3);
                sda_d = quarter[1];
                if (bit_end) state_nx = ST_CTRL_W;
            end
            ST_CTRL_W, ST_ADDR, ST_CTRL_R: begin
                scl_d = ~quarter[1];
                sda_d = ~tx_sh[7];
                if (byte_end) begin
                    if (state == ST_CTRL_W)    state_nx = ST_ACK_W;
                    else if (state == ST_ADDR) state_nx = ST_ACK_A;
                    else                       state_nx = ST_ACK_R;
                end
            end
            ST_ACK_W, ST_ACK_A, ST_ACK_R: begin
                scl_d = ~quarter[1];
                if (bit_end) begin
                    if (ack_bit)                state_nx = ST_STOP;
                    else if (state == ST_ACK_W) state_nx = ST_ADDR;
                    else if (state == ST_ACK_A) state_nx = ST_RSTART;
                    else                        state_nx = ST_READ;
                end
            end
            ST_RSTART: begin
                scl_d = ~quarter[1];
                sda_d = (quarter == 2'd3);
                if (bit_end) state_nx = ST_CTRL_R;
            end
            ST_READ: begin
                scl_d = ~quarter[1];
                if (byte_end) state_nx = ST_MACK;
            end
            ST_MACK: begin
                scl_d = ~quarter[1];
                sda_d = (remain != 9'd1);
                if (bit_end) begin
                    if (remain == 9'd1) state_nx = ST_STOP;
                    else                state_nx = ST_READ;
                end
            end
            ST_STOP: begin
                scl_d = ~quarter[1];
                sda_d = (quarter != 2'd3);
                if (bit_end) state_nx = ST_FIN;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt         <= '0;
            quarter      <= 2'd0;
            bit_cnt      <= 3'd0;
            tx_sh        <= 8'h00;
            rx_sh        <= 8'h00;
            addr_q       <= 8'h00;
            remain       <= 9'd0;
            err_flag     <= 1'b0;
            ack_bit      <= 1'b0;
            sda_sync     <= 2'b11;
            bus.scl_oe   <= 1'b0;
            bus.sda_oe   <= 1'b0;
            bus.rd_data  <= 8'h00;
            bus.rd_valid <= 1'b0;
        end else begin
            sda_sync     <= {sda_sync[0], bus.sda_i};
            bus.scl_oe   <= scl_d;
            bus.sda_oe   <= sda_d;
            bus.rd_valid <= 1'b0;
            if (accept) begin
                qcnt     <= '0;
                quarter  <= 2'd0;
                bit_cnt  <= 3'd0;
                addr_q   <= bus.start_addr;
                remain   <= bus.byte_count;
                err_flag <= 1'b0;
                tx_sh    <= {DEV_ADDR, 1'b0};
            end else if (active) begin
                qcnt <= q_end ? '0 : qcnt + QW'(1);
                if (q_end) quarter <= quarter + 2'd1;
                if (sample_pt) begin
                    if (state == ST_ACK_W || state == ST_ACK_A || state == ST_ACK_R)
                        ack_bit <= sda_sync[1];
                    if (state == ST_READ) begin
                        rx_sh <= {rx_sh[6:0], sda_sync[1]};
                        if (bit_cnt == 3'd7) begin
                            bus.rd_data  <= {rx_sh[6:0], sda_sync[1]};
                            bus.rd_valid <= 1'b1;
                        end
                    end
                end
                if (bit_end) begin
                    case (state)
                        ST_CTRL_W, ST_ADDR, ST_CTRL_R: begin
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        ST_READ:   bit_cnt <= bit_cnt + 3'd1;
                        ST_ACK_W: begin
                            tx_sh    <= addr_q;
                            err_flag <= ack_bit;
                        end
                        ST_ACK_A, ST_ACK_R: err_flag <= ack_bit;
                        ST_RSTART: tx_sh  <= {DEV_ADDR, 1'b1};
                        ST_MACK:   remain <= remain - 9'd1;
                        default: ;
                    endcase
                end
            end else begin
                qcnt    <= '0;
                quarter <= 2'd0;
            end
        end
    end
endmodule
`default_nettype wire
